// File: rtl/hazard_scoreboard_if.sv
// Operand-hazard bundle between the decode/issue pipeline and the scoreboard.
// The master side (pipeline) drives operand, issue, forwarding and writeback
// information. The slave side (scoreboard) returns stall/forward decisions
// and status.
interface hazard_scoreboard_if #(
  parameter int NUM_SRC = 3,
  parameter int NUM_FWD = 5,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5
);
  localparam int NREG = 2 ** ADDR_W;

  logic [NUM_SRC-1:0]             src_en;
  logic [NUM_SRC-1:0][ADDR_W-1:0] src_addr;
  logic                           iss_valid;
  logic                           iss_wen;
  logic                           iss_long;
  logic [ADDR_W-1:0]              iss_dst;
  logic [NUM_FWD-1:0]             fwd_valid;
  logic [NUM_FWD-1:0]             fwd_rdy;
  logic [NUM_FWD-1:0][ADDR_W-1:0] fwd_dst;
  logic [NUM_FWD-1:0][DATA_W-1:0] fwd_data;
  logic                           wb_valid;
  logic [ADDR_W-1:0]              wb_dst;
  logic                           flush;

  logic                           stall;
  logic                           clear;
  logic [NUM_SRC-1:0]             src_mux;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_fwd;
  logic [NREG-1:0]                pending;
  logic [31:0]                    stall_cycles;
  logic                           timeout_err;

  modport master (
    output src_en, src_addr, iss_valid, iss_wen, iss_long, iss_dst,
           fwd_valid, fwd_rdy, fwd_dst, fwd_data, wb_valid, wb_dst, flush,
    input  stall, clear, src_mux, src_fwd, pending, stall_cycles, timeout_err
  );

  modport slave (
    input  src_en, src_addr, iss_valid, iss_wen, iss_long, iss_dst,
           fwd_valid, fwd_rdy, fwd_dst, fwd_data, wb_valid, wb_dst, flush,
    output stall, clear, src_mux, src_fwd, pending, stall_cycles, timeout_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: forwarding source selection, RAW/WAW stall
// generation, pending-register tracking for variable-latency results, and
// a stall counter with a sticky watchdog.
module hazard_scoreboard #(
  parameter int          NUM_SRC = 3,
  parameter int          NUM_FWD = 5,
  parameter int          DATA_W  = 64,
  parameter int          ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  hazard_scoreboard_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [NREG-1:0]                pending_q, pending_d;
  logic [31:0]                    stall_cycles_q, stall_cycles_d;
  logic [31:0]                    run_q, run_d;
  logic                           timeout_q, timeout_d;

  logic [NUM_SRC-1:0]             hit_any;
  logic [NUM_SRC-1:0]             sel_rdy;
  logic [NUM_SRC-1:0]             blocked;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_fwd;
  logic                           waw;
  logic                           stall;
  logic                           accept;

  // Per-port priority select of the youngest matching forward source and
  // blocking decision (selected source not ready, or pending with no forward).
  always_comb begin
    hit_any = '0;
    sel_rdy = '0;
    src_fwd = '0;
    blocked = '0;
    for (int p = 0; p < NUM_SRC; p++) begin
      for (int f = 0; f < NUM_FWD; f++) begin
        if (!hit_any[p] && bus.fwd_valid[f] &&
            (bus.fwd_dst[f] == bus.src_addr[p]) && (bus.fwd_dst[f] != '0)) begin
          hit_any[p] = 1'b1;
          sel_rdy[p] = bus.fwd_rdy[f];
          src_fwd[p] = bus.fwd_data[f];
        end
      end
      blocked[p] = bus.src_en[p] && (bus.src_addr[p] != '0) &&
                   (hit_any[p] ? !sel_rdy[p] : pending_q[bus.src_addr[p]]);
    end
  end

  assign waw    = bus.iss_valid && bus.iss_wen && (bus.iss_dst != '0) &&
                  pending_q[bus.iss_dst];
  // Reset is folded in so the pipeline never sees a stall during reset.
  assign stall  = ((|blocked) || waw) && bus.iss_valid && !bus.flush && !reset;
  assign accept = bus.iss_valid && !stall && !bus.flush;

  // Scoreboard next state: flush wipes everything; otherwise the issue set
  // is applied after the writeback clear so the set wins on a collision.
  always_comb begin
    pending_d = pending_q;
    if (bus.flush) begin
      pending_d = '0;
    end else begin
      if (bus.wb_valid) begin
        pending_d[bus.wb_dst] = 1'b0;
      end
      if (accept && bus.iss_wen && bus.iss_long && (bus.iss_dst != '0)) begin
        pending_d[bus.iss_dst] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  // Saturating total stall count, consecutive-run counter and sticky watchdog.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    run_d          = '0;
    timeout_d      = timeout_q;
    if (stall) begin
      if (stall_cycles_q != CNT_MAX) begin
        stall_cycles_d = stall_cycles_q + 32'd1;
      end
      run_d = (run_q != CNT_MAX) ? run_q + 32'd1 : run_q;
      if (run_d >= TIMEOUT) begin
        timeout_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q      <= '0;
      stall_cycles_q <= '0;
      run_q          <= '0;
      timeout_q      <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      stall_cycles_q <= stall_cycles_d;
      run_q          <= run_d;
      timeout_q      <= timeout_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.clear        = stall;
  assign bus.src_mux      = hit_any;
  assign bus.src_fwd      = src_fwd;
  assign bus.pending      = pending_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.timeout_err  = timeout_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a table of single-cycle vectors with
// hand-computed results, followed by reset-during-stall and watchdog sequences.
module tb_hazard_scoreboard;
  localparam int NS = 3;
  localparam int NF = 5;
  localparam int DW = 64;
  localparam int AW = 5;

  typedef struct {
    logic [NS-1:0]         src_en;
    logic [NS-1:0][AW-1:0] src_addr;
    logic                  iss_valid;
    logic                  iss_wen;
    logic                  iss_long;
    logic [AW-1:0]         iss_dst;
    logic [NF-1:0]         fwd_valid;
    logic [NF-1:0]         fwd_rdy;
    logic [NF-1:0][AW-1:0] fwd_dst;
    logic [NF-1:0][DW-1:0] fwd_data;
    logic                  wb_valid;
    logic [AW-1:0]         wb_dst;
    logic                  flush;
    logic                  exp_stall;
    logic [NS-1:0]         exp_mux;
    logic [DW-1:0]         exp_fwd0;
    logic [DW-1:0]         exp_fwd1;
    logic [31:0]           exp_pend;
  } vec_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  hazard_scoreboard_if #(.NUM_SRC(NS), .NUM_FWD(NF), .DATA_W(DW), .ADDR_W(AW)) bus ();

  hazard_scoreboard #(
    .NUM_SRC(NS), .NUM_FWD(NF), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.src_en = '0; v.src_addr = '0; v.iss_valid = 1'b0; v.iss_wen = 1'b0;
    v.iss_long = 1'b0; v.iss_dst = '0; v.fwd_valid = '0; v.fwd_rdy = '0;
    v.fwd_dst = '0; v.fwd_data = '0; v.wb_valid = 1'b0; v.wb_dst = '0;
    v.flush = 1'b0; v.exp_stall = 1'b0; v.exp_mux = '0; v.exp_fwd0 = '0;
    v.exp_fwd1 = '0; v.exp_pend = '0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.src_en    = v.src_en;
    bus.src_addr  = v.src_addr;
    bus.iss_valid = v.iss_valid;
    bus.iss_wen   = v.iss_wen;
    bus.iss_long  = v.iss_long;
    bus.iss_dst   = v.iss_dst;
    bus.fwd_valid = v.fwd_valid;
    bus.fwd_rdy   = v.fwd_rdy;
    bus.fwd_dst   = v.fwd_dst;
    bus.fwd_data  = v.fwd_data;
    bus.wb_valid  = v.wb_valid;
    bus.wb_dst    = v.wb_dst;
    bus.flush     = v.flush;
  endtask

  // Issue a long-latency write to dst (no operands) and take one edge.
  task automatic issue_long(input logic [AW-1:0] dst);
    vec_t v;
    v = blank();
    v.iss_valid = 1'b1; v.iss_wen = 1'b1; v.iss_long = 1'b1; v.iss_dst = dst;
    @(negedge clk);
    drive(v);
    @(posedge clk);
  endtask

  initial begin
    vec_t vq[$];
    vec_t v;
    vec_t s;

    // 0: two sources hit x5, youngest (fwd0) wins
    v = blank(); v.iss_valid = 1; v.src_en = 3'b001; v.src_addr[0] = 5;
    v.fwd_valid = 5'b00101; v.fwd_rdy = 5'b11111; v.fwd_dst[0] = 5; v.fwd_dst[2] = 5;
    v.fwd_data[0] = 64'hA; v.fwd_data[2] = 64'hB;
    v.exp_mux = 3'b001; v.exp_fwd0 = 64'hA; vq.push_back(v);
    // 1: load-use, fwd0 not ready
    v = blank(); v.iss_valid = 1; v.src_en = 3'b010; v.src_addr[1] = 7;
    v.fwd_valid = 5'b00001; v.fwd_dst[0] = 7; v.fwd_data[0] = 64'h77;
    v.exp_stall = 1; v.exp_mux = 3'b010; v.exp_fwd1 = 64'h77; vq.push_back(v);
    // 2: same, ready rises -> forwarded, no stall
    v.fwd_rdy = 5'b00001; v.exp_stall = 0; vq.push_back(v);
    // 3: long issue to x9
    v = blank(); v.iss_valid = 1; v.iss_wen = 1; v.iss_long = 1; v.iss_dst = 9;
    v.exp_pend = 32'h200; vq.push_back(v);
    // 4: read x9, nothing forwarding -> stall
    v = blank(); v.iss_valid = 1; v.src_en = 3'b001; v.src_addr[0] = 9;
    v.exp_stall = 1; v.exp_pend = 32'h200; vq.push_back(v);
    // 5: writeback x9 arrives; still stalled this cycle
    v.wb_valid = 1; v.wb_dst = 9; v.exp_pend = 32'h0; vq.push_back(v);
    // 6: stall released
    v.wb_valid = 0; v.wb_dst = 0; v.exp_stall = 0; vq.push_back(v);
    // 7: issue long x4 and wb x4 together -> set wins
    v = blank(); v.iss_valid = 1; v.iss_wen = 1; v.iss_long = 1; v.iss_dst = 4;
    v.wb_valid = 1; v.wb_dst = 4; v.exp_pend = 32'h10; vq.push_back(v);
    // 8: x0 accesses with all sources targeting x0
    v = blank(); v.iss_valid = 1; v.src_en = 3'b111; v.fwd_valid = 5'b11111;
    v.fwd_data[0] = 64'h5555; v.exp_pend = 32'h10; vq.push_back(v);
    // 9: WAW on pending x4
    v = blank(); v.iss_valid = 1; v.iss_wen = 1; v.iss_long = 1; v.iss_dst = 4;
    v.exp_stall = 1; v.exp_pend = 32'h10; vq.push_back(v);
    // 10: wb x4 with no issue
    v = blank(); v.wb_valid = 1; v.wb_dst = 4; vq.push_back(v);
    // 11, 12: build pending = 0x300
    v = blank(); v.iss_valid = 1; v.iss_wen = 1; v.iss_long = 1; v.iss_dst = 8;
    v.exp_pend = 32'h100; vq.push_back(v);
    v.iss_dst = 9; v.exp_pend = 32'h300; vq.push_back(v);
    // 13: flush with a blocked read, an issue and a wb -> all ignored, cleared
    v = blank(); v.flush = 1; v.iss_valid = 1; v.iss_wen = 1; v.iss_long = 1;
    v.iss_dst = 5; v.src_en = 3'b001; v.src_addr[0] = 8; v.wb_valid = 1; v.wb_dst = 8;
    vq.push_back(v);
    // 14: long x3
    v = blank(); v.iss_valid = 1; v.iss_wen = 1; v.iss_long = 1; v.iss_dst = 3;
    v.exp_pend = 32'h8; vq.push_back(v);
    // 15: blocked read of x3 but no issue request -> no stall
    v = blank(); v.src_en = 3'b001; v.src_addr[0] = 3; v.exp_pend = 32'h8; vq.push_back(v);
    // 16: wb x3
    v = blank(); v.wb_valid = 1; v.wb_dst = 3; vq.push_back(v);
    // 17: short-latency write does not mark pending
    v = blank(); v.iss_valid = 1; v.iss_wen = 1; v.iss_dst = 6; vq.push_back(v);
    // 18: long write to x0 does not mark pending
    v.iss_long = 1; v.iss_dst = 0; vq.push_back(v);
    // 19: youngest hit not ready, older hit ready -> still stall on youngest
    v = blank(); v.iss_valid = 1; v.src_en = 3'b001; v.src_addr[0] = 5;
    v.fwd_valid = 5'b01010; v.fwd_rdy = 5'b01000; v.fwd_dst[1] = 5; v.fwd_dst[3] = 5;
    v.fwd_data[1] = 64'h11; v.fwd_data[3] = 64'h33;
    v.exp_stall = 1; v.exp_mux = 3'b001; v.exp_fwd0 = 64'h11; vq.push_back(v);

    // Reset, with a would-be stall presented
    reset = 1'b1;
    s = blank(); s.iss_valid = 1; s.iss_wen = 1; s.iss_dst = 1;
    drive(s);
    #1;
    check("reset_stall", {63'd0, bus.stall}, 64'd0);
    check("reset_clear", {63'd0, bus.clear}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_pending", {32'd0, bus.pending}, 64'd0);
    check("reset_stall_cycles", {32'd0, bus.stall_cycles}, 64'd0);
    check("reset_timeout", {63'd0, bus.timeout_err}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(blank());

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check($sformatf("v%0d_stall", i), {63'd0, bus.stall}, {63'd0, vq[i].exp_stall});
      check($sformatf("v%0d_clear", i), {63'd0, bus.clear}, {63'd0, vq[i].exp_stall});
      check($sformatf("v%0d_mux", i), {61'd0, bus.src_mux}, {61'd0, vq[i].exp_mux});
      check($sformatf("v%0d_fwd0", i), bus.src_fwd[0], vq[i].exp_fwd0);
      check($sformatf("v%0d_fwd1", i), bus.src_fwd[1], vq[i].exp_fwd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pending", i), {32'd0, bus.pending}, {32'd0, vq[i].exp_pend});
    end
    // Stalls in table: vectors 1, 4, 5, 9, 19
    check("table_stall_cycles", {32'd0, bus.stall_cycles}, 64'd5);
    check("table_timeout", {63'd0, bus.timeout_err}, 64'd0);

    // Reset in the middle of a stall
    @(negedge clk);
    drive(blank());
    @(posedge clk);
    issue_long(5'd9);
    @(negedge clk);
    s = blank(); s.iss_valid = 1; s.src_en = 3'b001; s.src_addr[0] = 9;
    drive(s);
    #1;
    check("midrst_stall_before", {63'd0, bus.stall}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_stall_in_reset", {63'd0, bus.stall}, 64'd0);
    check("midrst_clear_in_reset", {63'd0, bus.clear}, 64'd0);
    @(posedge clk);
    #1;
    check("midrst_pending", {32'd0, bus.pending}, 64'd0);
    check("midrst_stall_cycles", {32'd0, bus.stall_cycles}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_stall_after", {63'd0, bus.stall}, 64'd0);
    @(posedge clk);
    #1;
    check("midrst_stall_cycles_after", {32'd0, bus.stall_cycles}, 64'd0);

    // Watchdog with TIMEOUT=4
    issue_long(5'd10);
    @(negedge clk);
    s = blank(); s.iss_valid = 1; s.src_en = 3'b100; s.src_addr[2] = 10;
    drive(s);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("wd_timeout_%0d", k), {63'd0, bus.timeout_err}, (k == 3) ? 64'd1 : 64'd0);
    end
    check("wd_stall_cycles", {32'd0, bus.stall_cycles}, 64'd4);
    @(negedge clk);
    drive(blank());
    repeat (3) @(posedge clk);
    #1;
    check("wd_stall_dropped", {63'd0, bus.stall}, 64'd0);
    check("wd_sticky", {63'd0, bus.timeout_err}, 64'd1);
    check("wd_stall_cycles_hold", {32'd0, bus.stall_cycles}, 64'd4);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("wd_reset_clears", {63'd0, bus.timeout_err}, 64'd0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, meaning the number of operand read ports (rs, rt, csr).
REQ-002 SHALL have parameter NUM_FWD, default 5, meaning the number of forwarding sources; index 0 is the youngest and has the highest priority.
REQ-003 SHALL have parameter DATA_W, default 64, meaning the forwarded data width.
REQ-004 SHALL have parameter ADDR_W, default 5, meaning the register address width; NREG = 2**ADDR_W.
REQ-005 SHALL have parameter TIMEOUT, default 1024, meaning the consecutive stall cycles before a watchdog error.
REQ-006 SHALL have port clk, input, 1, the single clock; everything is on its rising edge.
REQ-007 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-008 SHALL have port src_en, input, NUM_SRC, meaning the read port is used by the decode-stage instruction.
REQ-009 SHALL have port src_addr, input, NUM_SRC x ADDR_W, the operand register addresses.
REQ-010 SHALL have port iss_valid, input, 1, meaning the decode instruction requests issue this cycle.
REQ-011 SHALL have port iss_wen, input, 1, meaning the issuing instruction writes a register.
REQ-012 SHALL have port iss_long, input, 1, meaning the issuing instruction is variable-latency (load, mul, div).
REQ-013 SHALL have port iss_dst, input, ADDR_W, the issuing instruction's destination.
REQ-014 SHALL have port fwd_valid, input, NUM_FWD, meaning the source will write fwd_dst.
REQ-015 SHALL have port fwd_rdy, input, NUM_FWD, meaning the source's fwd_data is final this cycle.
REQ-016 SHALL have port fwd_dst, input, NUM_FWD x ADDR_W, the forwarding source destinations.
REQ-017 SHALL have port fwd_data, input, NUM_FWD x DATA_W, the forwarding source data.
REQ-018 SHALL have port wb_valid, input, 1, meaning a long-latency result retires to the register file.
REQ-019 SHALL have port wb_dst, input, ADDR_W, the retiring destination.
REQ-020 SHALL have port flush, input, 1, a pipeline squash.
REQ-021 SHALL have port stall, output, 1, which holds fetch and decode.
REQ-022 SHALL have port clear, output, 1, which injects a bubble into execute.
REQ-023 SHALL have port src_mux, output, NUM_SRC, meaning use the forwarded value instead of the register file.
REQ-024 SHALL have port src_fwd, output, NUM_SRC x DATA_W, the forwarded operand values.
REQ-025 SHALL have port pending, output, NREG, the scoreboard state.
REQ-026 SHALL have port stall_cycles, output, 32, a saturating count of stalled cycles.
REQ-027 SHALL have port timeout_err, output, 1, a sticky watchdog error flag.

Function
REQ-028 SHALL compute hit for each port p and source f as fwd_valid[f] && fwd_dst[f]==src_addr[p] && fwd_dst[f]!=0.
REQ-029 SHALL have each port select the lowest-index hitting source, setting src_mux[p]=1 and src_fwd[p] to that source's data; with no hit, src_mux[p]=0 and src_fwd[p]=0.
REQ-030 SHALL make port p blocked when src_en[p] and src_addr[p]!=0 and either the selected source has fwd_rdy=0, or there is no hit and pending[src_addr[p]]=1.
REQ-031 SHALL flag a WAW hazard when iss_valid && iss_wen && iss_dst!=0 && pending[iss_dst].
REQ-032 SHALL drive stall = clear = (any port blocked || WAW) && iss_valid && !flush, combinationally with zero latency.
REQ-033 SHALL accept an issue when iss_valid && !stall && !flush.
REQ-034 SHALL set pending[iss_dst] at the next edge when an issue is accepted with iss_wen && iss_long && iss_dst!=0.
REQ-035 SHALL clear pending[wb_dst] at the next edge when wb_valid is high.
REQ-036 SHALL have the set win when a set and a clear hit the same register in the same cycle.
REQ-037 SHALL keep pending[0] at 0 at all times.
REQ-038 SHALL, on flush, clear all pending bits at the next edge, ignore issue and wb that cycle, and force stall=0.
REQ-039 SHALL increment stall_cycles by 1 on each cycle with stall=1, saturating at 0xFFFF_FFFF.
REQ-040 SHALL use a run counter that increments while stall=1 and resets to 0 when stall=0; timeout_err sets when the run reaches TIMEOUT and stays set until reset.
REQ-041 SHALL implement priority selection with parameterised loops; NUM_SRC=1 and NUM_FWD=1 SHALL be legal.

Reset
REQ-042 SHALL, with reset high at an edge, make pending=0, stall_cycles=0, the run counter 0 and timeout_err=0.
REQ-043 SHALL force stall=0 and clear=0 while reset is high.
REQ-044 SHALL, when reset occurs mid-stall, leave no stale pending bit and count no further stall cycles.

Verification
REQ-045 SHALL cover: fwd0 and fwd2 both valid with dst=5, rdy=1, data 0xA/0xB, src_addr[0]=5 -> src_mux[0]=1, src_fwd[0]=0xA, stall=0.
REQ-046 SHALL cover: a load-use case with fwd0 valid, dst=7, rdy=0, and src_addr[1]=7 enabled -> stall=clear=1; when rdy rises, stall falls and data is forwarded the same cycle.
REQ-047 SHALL cover: a long issue to x9, then src_addr[0]=9 with no forward -> stall held; wb_valid with wb_dst=9 -> pending[9]=0 next cycle and stall drops.
REQ-048 SHALL cover: an issue of long x4 and wb of x4 in the same cycle -> pending[4]=1; an access to x0 with all sources dst=0 -> no mux and no stall.
REQ-049 SHALL cover: flush while pending=0x0000_0300 -> pending=0 next cycle, and stall=0 during the flush cycle.
REQ-050 SHALL cover: with TIMEOUT=4, 4 consecutive stall cycles -> timeout_err=1 and stall_cycles=4; after stall drops, timeout_err remains 1 until reset.
